// File: rtl/floor_sequencer.sv
// Three-floor elevator sequencer: latches floor calls, drives travel and door dwell.
// Optional build macro REQ_CLEAR_ON_SOS_EN: sos_mode clears and suppresses latched calls.
module floor_sequencer #(
  parameter int unsigned DOOR_TIME = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       move_clk,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic       moving,
  output logic [1:0] current_floor,
  output logic       direction,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam int unsigned CntW = (DOOR_TIME > 1) ? $clog2(DOOR_TIME) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DOOR_TIME - 1);

  typedef enum logic [1:0] {StIdle, StMoving, StDoor} state_e;

  state_e          state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [2:0]      pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mc_q;

  logic [2:0] buttons;
  logic [2:0] calls;
  logic [2:0] pend_view;
  logic [2:0] here;
  logic [2:0] above;
  logic [2:0] below;
  logic [2:0] served;
  logic [1:0] nxt_floor;
  logic [2:0] nxt_mask;
  logic       step;

  assign buttons = {button3, button2, button1};

`ifdef REQ_CLEAR_ON_SOS_EN
  // Emergency stop discards every call, latched or arriving.
  assign calls     = sos_mode ? 3'b000 : buttons;
  assign pend_view = sos_mode ? 3'b000 : pend_q;
`else
  assign calls     = buttons;
  assign pend_view = pend_q;
`endif

  assign step     = move_clk & ~mc_q;
  assign here     = 3'b001 << floor_q;
  assign nxt_mask = 3'b001 << nxt_floor;

  always_comb begin
    above = 3'b000;
    below = 3'b000;
    unique case (floor_q)
      2'd0:    begin above = 3'b110; below = 3'b000; end
      2'd1:    begin above = 3'b100; below = 3'b001; end
      2'd2:    begin above = 3'b000; below = 3'b011; end
      default: begin above = 3'b000; below = 3'b000; end
    endcase
  end

  // Saturating neighbour so an out-of-range floor can never be produced.
  always_comb begin
    if (dir_q) begin
      nxt_floor = (floor_q == 2'd2) ? 2'd2 : floor_q + 2'd1;
    end else begin
      nxt_floor = (floor_q == 2'd0) ? 2'd0 : floor_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    served  = 3'b000;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (((pend_view | calls) & here) != 3'b000) begin
          state_d = StDoor;
          served  = here;
        end else if ((pend_view != 3'b000) && !sos_mode && !weight_limit_exceeded) begin
          state_d = StMoving;
          // Keep heading only if something is still waiting that way.
          if (dir_q ? ((pend_view & above) == 3'b000) : ((pend_view & below) == 3'b000)) begin
            dir_d = ~dir_q;
          end
        end
      end

      StMoving: begin
        if (sos_mode) begin
          state_d = StIdle;
        end else if (step) begin
          floor_d = nxt_floor;
          if (((pend_view | calls) & nxt_mask) != 3'b000) begin
            state_d = StDoor;
            served  = nxt_mask;
            cnt_d   = '0;
          end
        end
      end

      StDoor: begin
        // A call for the open floor only extends the dwell; it is never latched.
        served = here;
        if (weight_limit_exceeded || ((buttons & here) != 3'b000)) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    pend_d = (pend_view | calls) & ~served;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      floor_q <= 2'd0;
      dir_q   <= 1'b1;
      pend_q  <= 3'b000;
      cnt_q   <= '0;
      mc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mc_q    <= move_clk;
    end
  end

  assign moving        = (state_q == StMoving);
  assign door_open     = (state_q == StDoor);
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_floor_sequencer.sv
// Scoreboard bench for floor_sequencer: directed scenarios then random traffic,
// each cycle checked against a behavioural elevator model.
module tb_floor_sequencer;

  localparam int unsigned DT = 20;

  typedef struct packed {
    logic       mv;
    logic [1:0] fl;
    logic       dir;
    logic       door;
    logic [2:0] pend;
  } obs_t;

  localparam obs_t RstObs = 8'b0_00_1_0_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button1 = 1'b0, button2 = 1'b0, button3 = 1'b0;
  logic       move_clk = 1'b0;
  logic       sos_mode = 1'b0;
  logic       weight_limit_exceeded = 1'b0;
  logic       moving;
  logic [1:0] current_floor;
  logic       direction;
  logic       door_open;
  logic [2:0] pending;

  always #5 clk = ~clk;

  floor_sequencer #(.DOOR_TIME(DT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .button1               (button1),
    .button2               (button2),
    .button3               (button3),
    .move_clk              (move_clk),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .moving                (moving),
    .current_floor         (current_floor),
    .direction             (direction),
    .door_open             (door_open),
    .pending               (pending)
  );

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode 0 = parked, 1 = travelling, 2 = doors open.
  int m_mode;
  int m_floor;
  bit m_dir;
  bit m_pend[3];
  int m_left;
  bit m_prev;

  logic mc_v;
  logic rst_v;

  task automatic model_reset();
    m_mode  = 0;
    m_floor = 0;
    m_dir   = 1'b1;
    for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    m_left  = 0;
    m_prev  = 1'b0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.mv   = (m_mode == 1);
    o.fl   = 2'(m_floor);
    o.dir  = m_dir;
    o.door = (m_mode == 2);
    o.pend = {m_pend[2], m_pend[1], m_pend[0]};
    return o;
  endfunction

  task automatic model_step(input bit rst, input bit [2:0] b, input bit mc, input bit sos,
                            input bit wl);
    bit calls[3];
    bit pv[3];
    int served;
    bit step;
    bit any, up_wait, down_wait;
    if (!rst) begin
      model_reset();
      return;
    end
    step   = mc && !m_prev;
    m_prev = mc;
    served = -1;
    for (int i = 0; i < 3; i++) begin
      calls[i] = b[i];
      pv[i]    = m_pend[i];
    end
`ifdef REQ_CLEAR_ON_SOS_EN
    if (sos) begin
      for (int i = 0; i < 3; i++) begin
        calls[i] = 1'b0;
        pv[i]    = 1'b0;
      end
    end
`endif
    case (m_mode)
      0: begin
        if (pv[m_floor] || calls[m_floor]) begin
          m_mode = 2;
          m_left = DT;
          served = m_floor;
        end else begin
          any = 0; up_wait = 0; down_wait = 0;
          for (int i = 0; i < 3; i++) begin
            if (pv[i]) begin
              any = 1;
              if (i > m_floor) up_wait = 1;
              if (i < m_floor) down_wait = 1;
            end
          end
          if (any && !sos && !wl) begin
            m_mode = 1;
            if (m_dir ? !up_wait : !down_wait) m_dir = !m_dir;
          end
        end
      end
      1: begin
        if (sos) begin
          m_mode = 0;
        end else if (step) begin
          if (m_dir) m_floor = (m_floor >= 2) ? 2 : m_floor + 1;
          else       m_floor = (m_floor <= 0) ? 0 : m_floor - 1;
          if (pv[m_floor] || calls[m_floor]) begin
            m_mode = 2;
            m_left = DT;
            served = m_floor;
          end
        end
      end
      default: begin
        served = m_floor;
        if (wl || b[m_floor]) begin
          m_left = DT;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    for (int i = 0; i < 3; i++) m_pend[i] = (pv[i] || calls[i]) && (i != served);
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic tick(input logic [2:0] b, input logic s, input logic w);
    @(negedge clk);
    #1;
    rst_n                 = rst_v;
    {button3, button2, button1} = b;
    move_clk              = mc_v;
    sos_mode              = s;
    weight_limit_exceeded = w;
    model_step(rst_v, b, mc_v, s, w);
    exp_q.push_back(model_obs());
  endtask

  task automatic mc_edge();
    mc_v = 1'b1;
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    mc_v = 1'b0;
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick(3'b000, 1'b0, 1'b0);
  endtask

  // Mid-cycle reset: outputs must collapse before any clock edge.
  task automatic reset_now();
    obs_t got;
    @(negedge clk);
    #1;
    rst_v = 1'b0;
    rst_n = 1'b0;
    #1;
    got = {moving, current_floor, direction, door_open, pending};
    checks++;
    if (got !== RstObs) begin
      failures++;
      $display("FAIL async_reset t=%0t got=%b exp=%b", $time, got, RstObs);
    end
    model_step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_obs());
  endtask

  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {moving, current_floor, direction, door_open, pending};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got mv=%b fl=%0d dir=%b door=%b pend=%b exp mv=%b fl=%0d dir=%b door=%b pend=%b",
                   $time, got.mv, got.fl, got.dir, got.door, got.pend,
                   e.mv, e.fl, e.dir, e.door, e.pend);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0] b;
    logic       s;
    logic       w;
    model_reset();
    mc_v  = 1'b0;
    rst_v = 1'b0;
    wait_cycles(3);
    rst_v = 1'b1;

    // Call to the top floor, two steps up, full dwell.
    tick(3'b100, 1'b0, 1'b0);
    wait_cycles(3);
    mc_edge();
    mc_edge();
    wait_cycles(DT + 5);

    // Parked at floor 2 heading up, call below: reverses and travels down.
    tick(3'b001, 1'b0, 1'b0);
    wait_cycles(2);
    mc_edge();
    mc_edge();
    wait_cycles(DT + 5);

    // Call at the parked floor opens the door without moving.
    tick(3'b001, 1'b0, 1'b0);
    wait_cycles(DT + 3);

    // Emergency stop between floors, call latched during stop, then resume.
    tick(3'b100, 1'b0, 1'b0);
    wait_cycles(2);
    mc_edge();
    tick(3'b000, 1'b1, 1'b0);
    tick(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(3'b000, 1'b1, 1'b0);
    wait_cycles(3);
    mc_edge();
    wait_cycles(DT + 3);
    mc_edge();
    mc_edge();
    wait_cycles(DT + 5);

    // Overload holds the door open; dwell restarts on release.
    tick(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) tick(3'b000, 1'b0, 1'b1);
    wait_cycles(DT + 5);

    // Reset while travelling.
    tick(3'b100, 1'b0, 1'b0);
    wait_cycles(2);
    mc_edge();
    reset_now();
    wait_cycles(2);
    rst_v = 1'b1;
    wait_cycles(2);

    // Random traffic.
    s = 1'b0;
    w = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      b = 3'b000;
      if ($urandom_range(0, 11) == 0) b[$urandom_range(0, 2)] = 1'b1;
      if ($urandom_range(0, 2) == 0) mc_v = ~mc_v;
      if (s) s = ($urandom_range(0, 4) != 0);
      else   s = ($urandom_range(0, 79) == 0);
      if (w) w = ($urandom_range(0, 5) != 0);
      else   w = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset_now();
        tick(b, s, w);
        rst_v = 1'b1;
      end else begin
        tick(b, s, w);
      end
    end

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expectations exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
